// File: rtl/maze_tile_painter.sv
// Framebuffer writer: fills one maze tile, or clears the whole frame, by streaming
// raster-order pixel writes to the render SRAM port, holding each word WR_CYCLES clocks.
module maze_tile_painter #(
  parameter int H_RES     = 800,
  parameter int V_RES     = 600,
  parameter int TILE      = 20,
  parameter int WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [5:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic [23:0] cmd_color,
  output logic        busy,
  output logic        done,
  output logic        cmd_err,
  output logic        sram_wr_en,
  output logic [19:0] sram_wr_addr,
  output logic [31:0] sram_wr_data
);

  localparam logic [19:0] GRID_COLS  = 20'(H_RES / TILE);
  localparam logic [19:0] GRID_ROWS  = 20'(V_RES / TILE);
  localparam logic [19:0] LINE_STEP  = 20'(H_RES);
  localparam logic [19:0] FRAME_H    = 20'(V_RES);
  localparam logic [19:0] TILE_PIX   = 20'(TILE);
  localparam logic [19:0] TILE_STEP  = 20'(TILE * H_RES);
  localparam logic [3:0]  HOLD_LAST  = 4'(WR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_en_q, wr_en_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [19:0] x_q, x_d;
  logic [19:0] y_q, y_d;
  logic [19:0] line_base_q, line_base_d;
  logic [19:0] width_q, width_d;
  logic [19:0] height_q, height_d;
  logic [3:0]  hold_q, hold_d;

  logic tile_out_of_range;
  assign tile_out_of_range = (20'(cmd_col) >= GRID_COLS) || (20'(cmd_row) >= GRID_ROWS);

  always_comb begin
    // NOTE: every _d starts from its _q (or its idle value) so no path leaves a
    // variable unassigned; without these defaults synthesis would infer latches.
    state_d     = state_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_en_d     = wr_en_q;
    addr_d      = addr_q;
    data_d      = data_q;
    x_d         = x_q;
    y_d         = y_q;
    line_base_d = line_base_q;
    width_d     = width_q;
    height_d    = height_q;
    hold_d      = hold_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (!cmd_op && tile_out_of_range) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            wr_en_d = 1'b1;
            data_d  = {8'h00, cmd_color};
            x_d     = '0;
            y_d     = '0;
            hold_d  = '0;
            if (cmd_op) begin
              line_base_d = '0;
              width_d     = LINE_STEP;
              height_d    = FRAME_H;
            end else begin
              line_base_d = 20'(cmd_row) * TILE_STEP + 20'(cmd_col) * TILE_PIX;
              width_d     = TILE_PIX;
              height_d    = TILE_PIX;
            end
            addr_d = line_base_d;
          end
        end
      end

      S_WRITE: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (x_q == width_q - 20'd1) begin
            if (y_q == height_q - 20'd1) begin
              state_d = S_DONE;
              wr_en_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_d         = '0;
              y_d         = y_q + 20'd1;
              line_base_d = line_base_q + LINE_STEP;
              addr_d      = line_base_q + LINE_STEP;
            end
          end else begin
            x_d    = x_q + 20'd1;
            addr_d = addr_q + 20'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      width_q     <= width_d;
      height_q    <= height_d;
      hold_q      <= hold_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd_err      = err_q;
  assign sram_wr_en   = wr_en_q;
  assign sram_wr_addr = addr_q;
  assign sram_wr_data = data_q;

endmodule

// File: doc/maze_tile_painter.md
Name: maze_tile_painter

Overview:
- Framebuffer writer directly upstream of the render stage. Accepts draw commands and drives render's SRAM write port (sram_wr_en / sram_wr_addr / sram_wr_data).
- Supports two commands: fill one maze tile with a solid colour, or clear the whole 800x600 frame to a colour.
- Framebuffer layout: one 32-bit word per pixel, address = y*H_RES + x, data = {8'h00, R, G, B}.

Parameters:
- H_RES, 800, horizontal pixels per line (framebuffer stride).
- V_RES, 600, visible lines.
- TILE, 20, tile edge in pixels. Grid is H_RES/TILE = 40 columns by V_RES/TILE = 30 rows.
- WR_CYCLES, 2, clk cycles each write is held on the port (SRAM write timing at 100 MHz). Range 1..15.

Ports:
- clk  input  1  system clock, 100 MHz, same clock as render's sram_controller.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  1  0 = fill tile, 1 = clear frame.
- cmd_col  input  6  tile column, 0..39.
- cmd_row  input  5  tile row, 0..29.
- cmd_color  input  24  {R[23:16], G[15:8], B[7:0]}.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse when a command completes or is rejected.
- cmd_err  output  1  one-cycle pulse, coincident with done, when a command is rejected.
- sram_wr_en  output  1  write strobe to render.
- sram_wr_addr  output  20  pixel word address.
- sram_wr_data  output  32  pixel word.

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; busy=0; done=0; cmd_err=0; sram_wr_en=0; sram_wr_addr=0; sram_wr_data=0. Counters are cleared.
- Reset mid-operation: writes stop immediately and the command is abandoned; no done pulse is produced.
- Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready. cmd_ready = (state==IDLE), registered. Command fields are sampled only at the transfer edge.
- State IDLE:
  - op=0 with cmd_col>=40 or cmd_row>=30: go to DONE with cmd_err=1. No SRAM write is issued.
  - otherwise: latch the colour, compute the geometry and go to WRITE.
- Geometry:
  - op=0: origin = cmd_row*TILE*H_RES + cmd_col*TILE; width = height = TILE.
  - op=1: origin = 0; width = H_RES; height = V_RES.
  - Arithmetic is 20-bit unsigned. Maximum address is 479999, so nothing wraps.
- State WRITE:
  - sram_wr_en=1. sram_wr_addr = line_base + x; sram_wr_data = {8'h00, colour}.
  - Each pixel is held for exactly WR_CYCLES consecutive cycles, then x increments.
  - When x reaches width-1 and its hold ends: x=0, line_base += H_RES, y++.
  - After the last pixel's hold (x=width-1, y=height-1): go to DONE.
  - sram_wr_en stays high continuously across pixel boundaries.
  - Pixel order is raster order: left to right within a line, top to bottom across lines.
- State DONE: lasts one cycle. done=1; sram_wr_en=0; cmd_ready=0. Next state is IDLE.
- Latency:
  - The first write beat is on the cycle after acceptance.
  - Beat count is width*height*WR_CYCLES. Tile: 400*2 = 800 cycles. Clear: 480000*2 = 960000 cycles.
  - done is on the cycle after the last beat. The next command can be accepted on the cycle after done.
- busy = (state==WRITE) || (state==DONE).
- cmd_valid asserted while busy: the command is held off, not dropped, and accepted at IDLE.
- Outputs are all registered, with no combinational path from cmd_* to sram_*.
- sram_wr_addr and sram_wr_data hold their last values while sram_wr_en=0.

Test Plan:
- Reset mid-tile: reset after 37 beats -> sram_wr_en=0 at once; no done pulse; cmd_ready=1 after release; a new tile then completes normally.
- Fill tile col=0 row=0 colour 24'hFF0000 -> 800 beats. Addresses 0,0,1,1,..,19,19,800,800,..,15219,15219. Data 32'h00FF0000 throughout. done pulses once; cmd_err=0.
- Fill tile col=39 row=29 colour 24'h00FF00 -> first addr 29*16000+780 = 464780, last addr 479999. Beat count 800. Nothing is written outside that tile.
- Invalid tile col=40 row=3 -> no sram_wr_en at all. done=1 and cmd_err=1 on the cycle after acceptance.
- Back-to-back: cmd_valid held high with two commands queued -> the second transfers only after the first's done. cmd_ready=0 throughout the first command's WRITE and DONE.
- Clear frame colour 24'h000000 with WR_CYCLES=1 -> 480000 contiguous beats, addresses 0..479999 in order. done occurs 480001 cycles after acceptance.
